spike_event_encoder: RTL and testbench

Consumes the membrane-potential stream `v` produced by the neuron core and turns it into timestamped spike events. Spikes are detected with a two-threshold hysteresis, the peak of each spike is tracked, and each completed spike is pushed into a small FIFO. The FIFO drains over a valid/ready handshake toward the host or AER link. The block is the read-side end of the core's state output, so it shares the core's Q3.12 signed fixed-point format.

---
 rtl/spike_event_encoder.sv | 163 ++++++++++++++++
 tb/tb_spike_event_encoder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// Hysteresis spike detector for the Q3.12 membrane-potential stream. Each completed
// spike's timestamp and peak go into a first-word-fall-through event FIFO.
module spike_event_encoder #(
  parameter int int_width  = 3,
  parameter int frc_width  = 12,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter logic signed [int_width+frc_width:0] UP_THRESH   = 16'sd2048,
  parameter logic signed [int_width+frc_width:0] DOWN_THRESH = -16'sd2048,
  parameter int REFRACT    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic signed [int_width+frc_width:0]   v_in,
  input  logic                                  v_valid,
  output logic                                  ev_valid,
  input  logic                                  ev_ready,
  output logic [TS_WIDTH-1:0]                   ev_ts,
  output logic signed [int_width+frc_width:0]   ev_peak,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
  output logic                                  overflow,
  output logic [7:0]                            drop_count
);

  localparam int W   = 1 + int_width + frc_width;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = TS_WIDTH + W;
  localparam int RCW = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;

  typedef enum logic [1:0] {
    S_WAIT_LOW,
    S_ARMED,
    S_SPIKE,
    S_REFRACT
  } state_t;

  state_t                state_reg, state_next;
  logic [TS_WIDTH-1:0]   ts_cnt_reg;
  logic [TS_WIDTH-1:0]   ts_lat_reg, ts_lat_next;
  logic signed [W-1:0]   peak_reg, peak_next;
  logic [RCW-1:0]        rcnt_reg, rcnt_next;
  logic                  push;
  logic                  accept;

  assign accept = en & v_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_WAIT_LOW;
      ts_cnt_reg <= '0;
      ts_lat_reg <= '0;
      peak_reg   <= '0;
      rcnt_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      ts_lat_reg <= ts_lat_next;
      peak_reg   <= peak_next;
      rcnt_reg   <= rcnt_next;
      if (accept)
        ts_cnt_reg <= ts_cnt_reg + TS_WIDTH'(1);
    end
  end

  always_comb begin
    state_next  = state_reg;
    ts_lat_next = ts_lat_reg;
    peak_next   = peak_reg;
    rcnt_next   = rcnt_reg;
    push        = 1'b0;
    if (accept) begin
      case (state_reg)
        S_WAIT_LOW: begin
          // Require a low sample first so a stream that starts high cannot fake a spike.
          if (v_in <= DOWN_THRESH)
            state_next = S_ARMED;
        end
        S_ARMED: begin
          if (v_in >= UP_THRESH) begin
            ts_lat_next = ts_cnt_reg;
            peak_next   = v_in;
            state_next  = S_SPIKE;
          end
        end
        S_SPIKE: begin
          if (v_in <= DOWN_THRESH) begin
            push = 1'b1;
            if (REFRACT == 0) begin
              state_next = S_ARMED;
            end else begin
              rcnt_next  = RCW'(REFRACT);
              state_next = S_REFRACT;
            end
          end else if (v_in > peak_reg) begin
            peak_next = v_in;
          end
        end
        S_REFRACT: begin
          rcnt_next = rcnt_reg - RCW'(1);
          if (rcnt_reg == RCW'(1))
            state_next = S_ARMED;
        end
        default: state_next = S_WAIT_LOW;
      endcase
    end
  end

  // Event FIFO: a small array read asynchronously so the head is visible without a bubble.
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    level_reg;
  logic           overflow_reg;
  logic [7:0]     drop_count_reg;
  logic           full;
  logic           pop;
  logic           wr_en;
  logic           drop;
  logic [EW-1:0]  head;

  assign ev_valid = (level_reg != '0);
  assign full     = (level_reg == (AW+1)'(FIFO_DEPTH));
  assign pop      = ev_valid & ev_ready;
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= {ts_lat_reg, peak_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 8'hFF)
          drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign ev_ts      = ev_valid ? head[EW-1:W] : '0;
  assign ev_peak    = ev_valid ? head[W-1:0] : '0;
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder with a 4-bit timestamp so wrap is reachable.
module tb_spike_event_encoder;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [15:0] v_in;
  logic               v_valid;
  logic               ev_valid;
  logic               ev_ready;
  logic [3:0]         ev_ts;
  logic signed [15:0] ev_peak;
  logic [3:0]         fifo_level;
  logic               overflow;
  logic [7:0]         drop_count;

  int vectors;
  int miscompares;

  spike_event_encoder #(
    .TS_WIDTH   (4),
    .FIFO_DEPTH (8),
    .REFRACT    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .v_in       (v_in),
    .v_valid    (v_valid),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_ts      (ev_ts),
    .ev_peak    (ev_peak),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] s);
    v_in    = s;
    v_valid = 1'b1;
    tick();
    v_valid = 1'b0;
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic spike(input logic signed [15:0] pk);
    send(pk);
    send(-16'sd2048);
    for (int j = 0; j < 4; j++) send(16'sd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({ev_valid, ev_ts, ev_peak, fifo_level, overflow, drop_count} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%0d ts=%0d peak=%0d lvl=%0d ovf=%0d drops=%0d want all 0",
               ev_valid, ev_ts, ev_peak, fifo_level, overflow, drop_count);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send(-16'sd4096);
    send(16'sd0);
    send(16'sd2048);
    send(16'sd3000);
    send(16'sd2500);
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_valid got %0d want 0", ev_valid);
    end
    send(-16'sd2048);
    vectors++;
    if ({ev_valid, ev_ts, ev_peak, fifo_level} !== {1'b1, 4'd2, 16'sd3000, 4'd1}) begin
      miscompares++;
      $display("FAIL basic_event got v=%0d ts=%0d peak=%0d lvl=%0d want v=1 ts=2 peak=3000 lvl=1",
               ev_valid, ev_ts, ev_peak, fifo_level);
    end
    pop_one();
    vectors++;
    if ({ev_valid, fifo_level} !== {1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL basic_pop got v=%0d lvl=%0d want v=0 lvl=0", ev_valid, fifo_level);
    end
  endtask

  task automatic test_wait_low();
    do_reset();
    send(16'sd4000);
    send(16'sd4000);
    vectors++;
    if ({ev_valid, fifo_level} !== {1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL waitlow_high_start got v=%0d lvl=%0d want v=0 lvl=0", ev_valid, fifo_level);
    end
    send(-16'sd2048);
    send(16'sd2048);
    // ready asserted on the push cycle while empty: the push must still land
    ev_ready = 1'b1;
    send(-16'sd2048);
    ev_ready = 1'b0;
    vectors++;
    if ({ev_valid, ev_ts, ev_peak, fifo_level} !== {1'b1, 4'd3, 16'sd2048, 4'd1}) begin
      miscompares++;
      $display("FAIL waitlow_event got v=%0d ts=%0d peak=%0d lvl=%0d want v=1 ts=3 peak=2048 lvl=1",
               ev_valid, ev_ts, ev_peak, fifo_level);
    end
    pop_one();
  endtask

  task automatic test_refract();
    do_reset();
    send(-16'sd2048);
    send(16'sd2048);
    send(16'sd3000);
    send(16'sd1000);
    send(16'sd0);
    send(-16'sd2048);
    for (int j = 0; j < 4; j++) send(16'sd2048);
    send(-16'sd2048);
    send(16'sd2048);
    send(-16'sd2048);
    vectors++;
    if ({ev_ts, ev_peak, fifo_level} !== {4'd1, 16'sd3000, 4'd2}) begin
      miscompares++;
      $display("FAIL refract_first got ts=%0d peak=%0d lvl=%0d want ts=1 peak=3000 lvl=2",
               ev_ts, ev_peak, fifo_level);
    end
    pop_one();
    vectors++;
    if ({ev_valid, ev_ts, ev_peak} !== {1'b1, 4'd11, 16'sd2048}) begin
      miscompares++;
      $display("FAIL refract_second got v=%0d ts=%0d peak=%0d want v=1 ts=11 peak=2048",
               ev_valid, ev_ts, ev_peak);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [3:0]         exp_ts;
    logic signed [15:0] exp_pk;
    do_reset();
    ev_ready = 1'b0;
    send(-16'sd2048);
    for (int i = 0; i < 10; i++) begin
      spike(16'(2048 + 100 * i));
      if (i == 7) begin
        vectors++;
        if ({fifo_level, overflow, drop_count} !== {4'd8, 1'b0, 8'd0}) begin
          miscompares++;
          $display("FAIL ovf_just_full got lvl=%0d ovf=%0d drops=%0d want lvl=8 ovf=0 drops=0",
                   fifo_level, overflow, drop_count);
        end
      end
    end
    vectors++;
    if ({fifo_level, overflow, drop_count} !== {4'd8, 1'b1, 8'd2}) begin
      miscompares++;
      $display("FAIL ovf_drops got lvl=%0d ovf=%0d drops=%0d want lvl=8 ovf=1 drops=2",
               fifo_level, overflow, drop_count);
    end
    for (int k = 0; k < 8; k++) begin
      exp_ts = 4'((1 + 6 * k) % 16);
      exp_pk = 16'(2048 + 100 * k);
      vectors++;
      if ({ev_valid, ev_ts, ev_peak} !== {1'b1, exp_ts, exp_pk}) begin
        miscompares++;
        $display("FAIL ovf_drain%0d got v=%0d ts=%0d peak=%0d want v=1 ts=%0d peak=%0d",
                 k, ev_valid, ev_ts, ev_peak, exp_ts, exp_pk);
      end
      pop_one();
    end
    vectors++;
    if ({ev_valid, fifo_level, overflow, drop_count} !== {1'b0, 4'd0, 1'b1, 8'd2}) begin
      miscompares++;
      $display("FAIL ovf_empty got v=%0d lvl=%0d ovf=%0d drops=%0d want v=0 lvl=0 ovf=1 drops=2",
               ev_valid, fifo_level, overflow, drop_count);
    end
  endtask

  task automatic test_push_pop_full();
    logic [3:0]         exp_ts;
    logic signed [15:0] exp_pk;
    do_reset();
    vectors++;
    if ({overflow, drop_count} !== {1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_clears_ovf got ovf=%0d drops=%0d want 0 0", overflow, drop_count);
    end
    send(-16'sd2048);
    for (int i = 0; i < 8; i++) spike(16'(2048 + 100 * i));
    send(16'sd2848);
    ev_ready = 1'b1;
    send(-16'sd2048);
    ev_ready = 1'b0;
    vectors++;
    if ({fifo_level, overflow, drop_count} !== {4'd8, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL pushpop_full got lvl=%0d ovf=%0d drops=%0d want lvl=8 ovf=0 drops=0",
               fifo_level, overflow, drop_count);
    end
    for (int k = 1; k < 9; k++) begin
      exp_ts = 4'((1 + 6 * k) % 16);
      exp_pk = 16'(2048 + 100 * k);
      vectors++;
      if ({ev_valid, ev_ts, ev_peak} !== {1'b1, exp_ts, exp_pk}) begin
        miscompares++;
        $display("FAIL pushpop_drain%0d got v=%0d ts=%0d peak=%0d want v=1 ts=%0d peak=%0d",
                 k, ev_valid, ev_ts, ev_peak, exp_ts, exp_pk);
      end
      pop_one();
    end
    vectors++;
    if ({ev_valid, fifo_level} !== {1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL pushpop_empty got v=%0d lvl=%0d want v=0 lvl=0", ev_valid, fifo_level);
    end
  endtask

  task automatic test_enable_wrap();
    do_reset();
    send(-16'sd2048);
    for (int j = 0; j < 14; j++) send(16'sd0);
    en      = 1'b0;
    v_valid = 1'b1;
    v_in    = 16'sd4000;
    for (int j = 0; j < 5; j++) tick();
    v_valid = 1'b0;
    en      = 1'b1;
    vectors++;
    if ({ev_valid, fifo_level} !== {1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL en_low_ignored got v=%0d lvl=%0d want v=0 lvl=0", ev_valid, fifo_level);
    end
    send(16'sd2048);
    send(-16'sd2048);
    vectors++;
    if ({ev_valid, ev_ts, ev_peak} !== {1'b1, 4'd15, 16'sd2048}) begin
      miscompares++;
      $display("FAIL wrap_first got v=%0d ts=%0d peak=%0d want v=1 ts=15 peak=2048",
               ev_valid, ev_ts, ev_peak);
    end
    // FIFO must still drain while en is low
    en       = 1'b0;
    v_valid  = 1'b1;
    v_in     = 16'sd4000;
    ev_ready = 1'b1;
    tick();
    en       = 1'b1;
    v_valid  = 1'b0;
    ev_ready = 1'b0;
    vectors++;
    if ({ev_valid, fifo_level} !== {1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL en_low_drain got v=%0d lvl=%0d want v=0 lvl=0", ev_valid, fifo_level);
    end
    for (int j = 0; j < 4; j++) send(16'sd0);
    send(16'sd2048);
    send(-16'sd2048);
    vectors++;
    if ({ev_valid, ev_ts, ev_peak} !== {1'b1, 4'd5, 16'sd2048}) begin
      miscompares++;
      $display("FAIL wrap_second got v=%0d ts=%0d peak=%0d want v=1 ts=5 peak=2048",
               ev_valid, ev_ts, ev_peak);
    end
    pop_one();
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(-16'sd2048);
    for (int i = 0; i < 3; i++) spike(16'(2500 + i));
    send(16'sd3000);
    vectors++;
    if (fifo_level !== 4'd3) begin
      miscompares++;
      $display("FAIL midrst_setup got lvl=%0d want 3", fifo_level);
    end
    rst     = 1'b1;
    v_valid = 1'b1;
    v_in    = -16'sd2048;
    tick();
    rst     = 1'b0;
    v_valid = 1'b0;
    vectors++;
    if ({ev_valid, ev_ts, ev_peak, fifo_level, overflow, drop_count} !== 34'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs got v=%0d ts=%0d peak=%0d lvl=%0d ovf=%0d drops=%0d want all 0",
               ev_valid, ev_ts, ev_peak, fifo_level, overflow, drop_count);
    end
    send(-16'sd2048);
    vectors++;
    if (fifo_level !== 4'd0) begin
      miscompares++;
      $display("FAIL midrst_no_stale_spike got lvl=%0d want 0", fifo_level);
    end
    send(16'sd2048);
    send(-16'sd2048);
    vectors++;
    if ({ev_valid, ev_ts, ev_peak, fifo_level} !== {1'b1, 4'd1, 16'sd2048, 4'd1}) begin
      miscompares++;
      $display("FAIL midrst_event got v=%0d ts=%0d peak=%0d lvl=%0d want v=1 ts=1 peak=2048 lvl=1",
               ev_valid, ev_ts, ev_peak, fifo_level);
    end
    pop_one();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    en          = 1'b1;
    v_in        = '0;
    v_valid     = 1'b0;
    ev_ready    = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_wait_low();
    test_refract();
    test_overflow();
    test_push_pop_full();
    test_enable_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
